// File: rtl/jt51_ym3012_pkg.sv
// Shared constants and FSM encoding for the YM3012-style serial DAC receiver.
package jt51_ym3012_pkg;

    localparam int MAN_W   = 10;
    localparam int EXP_W   = 3;
    localparam int MAN_LSB = 0;
    localparam int EXP_LSB = MAN_LSB + MAN_W;
    localparam int FIELD_W = EXP_LSB + EXP_W;
    localparam int LIN_W   = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT1  = 2'd1,
        SHIFT2  = 2'd2,
        ERRWAIT = 2'd3
    } rx_state_e;

endpackage

// File: rtl/jt51_exp2lin.sv
// Floating-point DAC word expander: 10-bit two's complement mantissa, 3-bit exponent
// to 16-bit linear PCM. exp=0 is silence; exp=k scales by 2^(k-1).
module jt51_exp2lin
    import jt51_ym3012_pkg::*;
(
    input  logic [MAN_W-1:0] man_i,
    input  logic [EXP_W-1:0] exp_i,
    output logic [LIN_W-1:0] lin_o
);

    logic [LIN_W-1:0] ext;

    assign ext = {{(LIN_W-MAN_W){man_i[MAN_W-1]}}, man_i};

    always_comb begin
        lin_o = '0;
        if (exp_i != '0) begin
            lin_o = ext << (exp_i - 3'd1);
        end
    end

endmodule

// File: rtl/jt51_ym3012_rx.sv
// Deserialises the so/sh1/sh2 stream, checks word framing and presents decoded
// left/right pairs. Valid/ready-free: sample_valid and frame_err are 1-clk strobes.
module jt51_ym3012_rx
    import jt51_ym3012_pkg::*;
#(
    parameter int WORD_BITS = 16,
    parameter bit SWAP      = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic             so,
    input  logic             sh1,
    input  logic             sh2,
    output logic [LIN_W-1:0] left,
    output logic [LIN_W-1:0] right,
    output logic             sample_valid,
    output logic             frame_err,
    output rx_state_e        dbg_state_o
);

    localparam int CW = $clog2(WORD_BITS + 1);

    rx_state_e             state_q, state_d;
    logic [1:0]            ign_q, ign_d;
    logic [WORD_BITS-1:0]  sreg_q, sreg_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [LIN_W-1:0]      pend_q, pend_d;
    logic [LIN_W-1:0]      ch2_q, ch2_d;
    logic                  pair_q, pair_d;
    logic [LIN_W-1:0]      left_q, left_d;
    logic [LIN_W-1:0]      right_q, right_d;
    logic                  sv_q, sv_d;
    logic                  fe_q, fe_d;

    logic                  cnt_full;
    logic                  take_start;
    logic [LIN_W-1:0]      lin;

    jt51_exp2lin u_exp2lin (
        .man_i (sreg_q[MAN_LSB +: MAN_W]),
        .exp_i (sreg_q[EXP_LSB +: EXP_W]),
        .lin_o (lin)
    );

    generate
        if (WORD_BITS > FIELD_W) begin : g_pad
            logic pad_unused;
            assign pad_unused = ^sreg_q[WORD_BITS-1:FIELD_W];
        end
    endgenerate

    assign cnt_full = (cnt_q == CW'(WORD_BITS));

    always_comb begin
        state_d    = state_q;
        ign_d      = ign_q;
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        ch2_d      = ch2_q;
        pair_d     = pair_q;
        left_d     = left_q;
        right_d    = right_q;
        sv_d       = 1'b0;
        fe_d       = 1'b0;
        take_start = 1'b0;

        if (cen) begin
            // A ch2 word accepted on the previous bit time is published now.
            if (pair_q) begin
                left_d  = SWAP ? ch2_q : pend_q;
                right_d = SWAP ? pend_q : ch2_q;
                sv_d    = 1'b1;
                pair_d  = 1'b0;
            end

            if (sh1 && sh2) begin
                fe_d    = (state_q != ERRWAIT);
                state_d = ERRWAIT;
                ign_d   = 2'b11;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    IDLE: take_start = 1'b1;
                    SHIFT1: begin
                        if (sh1) begin
                            if (cnt_full) begin
                                fe_d    = 1'b1;
                                state_d = ERRWAIT;
                                ign_d   = 2'b01;
                                cnt_d   = '0;
                            end else begin
                                sreg_d = sreg_q | (WORD_BITS'(so) << cnt_q);
                                cnt_d  = cnt_q + CW'(1);
                            end
                        end else begin
                            if (cnt_full) pend_d = lin;
                            else          fe_d   = 1'b1;
                            take_start = 1'b1;
                        end
                    end
                    SHIFT2: begin
                        if (sh2) begin
                            if (cnt_full) begin
                                fe_d    = 1'b1;
                                state_d = ERRWAIT;
                                ign_d   = 2'b10;
                                cnt_d   = '0;
                            end else begin
                                sreg_d = sreg_q | (WORD_BITS'(so) << cnt_q);
                                cnt_d  = cnt_q + CW'(1);
                            end
                        end else begin
                            if (cnt_full) begin
                                ch2_d  = lin;
                                pair_d = 1'b1;
                            end else begin
                                fe_d = 1'b1;
                            end
                            take_start = 1'b1;
                        end
                    end
                    ERRWAIT: begin
                        // Keep ignoring only the strobe(s) whose high period was rejected.
                        if (!((sh1 && ign_q[0]) || (sh2 && ign_q[1]))) begin
                            take_start = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end

            if (take_start) begin
                ign_d = 2'b00;
                if (sh1) begin
                    state_d = SHIFT1;
                    sreg_d  = WORD_BITS'(so);
                    cnt_d   = CW'(1);
                end else if (sh2) begin
                    state_d = SHIFT2;
                    sreg_d  = WORD_BITS'(so);
                    cnt_d   = CW'(1);
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ign_q   <= 2'b00;
            sreg_q  <= '0;
            cnt_q   <= '0;
            pend_q  <= '0;
            ch2_q   <= '0;
            pair_q  <= 1'b0;
            left_q  <= '0;
            right_q <= '0;
            sv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ign_q   <= ign_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ch2_q   <= ch2_d;
            pair_q  <= pair_d;
            left_q  <= left_d;
            right_q <= right_d;
            sv_q    <= sv_d;
            fe_q    <= fe_d;
        end
    end

    assign left         = left_q;
    assign right        = right_q;
    assign sample_valid = sv_q;
    assign frame_err    = fe_q;
    assign dbg_state_o  = state_q;

endmodule
